preio_f2a_lane_arbiter: RTL and testbench

Shares one fabric-to-SoC lane of DATA_W PREIO pads among NUM_REQ fabric requesters.
- Arbitration is round-robin with whole-burst ownership.
- Per-beat valid/ready handshake, with backpressure from a SoC ready flag returned over an A2F pad.
- Watchdog aborts stalled bursts.
- Sits in the IO tile cluster between the fabric logic and the pad_outpad inputs of a group of RS_PREIO pad tiles.

---
 rtl/preio_pkg.sv | 21 ++
 rtl/preio_rr_picker.sv | 34 +++
 rtl/preio_f2a_lane_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_preio_f2a_lane_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preio_pkg.sv
// Shared types and default widths for the PREIO fabric-to-SoC lane arbiter.
package preio_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
        logic err;
    } lane_ctrl_t;

endpackage

// File: rtl/preio_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module preio_rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant_c,
    output logic [$clog2(NUM_REQ)-1:0] idx_c,
    output logic                       any_c
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    int unsigned cand;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any_c && req[IW'(cand)]) begin
                any_c               = 1'b1;
                idx_c               = IW'(cand);
                grant_c[IW'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/preio_f2a_lane_arbiter.sv
// Round-robin, whole-burst arbiter sharing one PREIO fabric-to-SoC lane among
// NUM_REQ requesters, with SoC backpressure and a stall watchdog.
module preio_f2a_lane_arbiter
    import preio_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = preio_pkg::DATA_W,
    parameter int unsigned LEN_W      = preio_pkg::LEN_W,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*LEN_W-1:0]     req_len,
    output logic [NUM_REQ-1:0]           req_grant,
    input  logic [NUM_REQ*DATA_W-1:0]    beat_data,
    input  logic [NUM_REQ-1:0]           beat_valid,
    output logic [NUM_REQ-1:0]           beat_ready,
    input  logic                         soc_ready_pad,
    output logic [DATA_W-1:0]            lane_data,
    output logic                         lane_valid,
    output logic                         lane_sof,
    output logic                         lane_eof,
    output logic                         lane_err,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   cur_owner
);

    localparam int unsigned OWN_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT);
    localparam int unsigned GAP_W = 4;

    state_t              state, state_n;
    logic [OWN_W-1:0]    owner, owner_n;
    logic [OWN_W-1:0]    rr_ptr, rr_ptr_n;
    logic [LEN_W-1:0]    len_q, len_n;
    logic [LEN_W-1:0]    cnt, cnt_n;
    logic [WD_W-1:0]     wd, wd_n;
    logic [GAP_W-1:0]    gap_cnt, gap_n;
    logic                soc_rdy_q;
    lane_ctrl_t          ctrl, ctrl_n;
    logic [DATA_W-1:0]   data_n;
    logic [NUM_REQ-1:0]  grant_n, ready_n;
    logic                busy_n;
    logic                done_c;

    logic [NUM_REQ-1:0]  pick_onehot_c;
    logic [OWN_W-1:0]    pick_idx_c;
    logic                pick_any_c;
    logic [LEN_W-1:0]    pick_len_c;
    logic [DATA_W-1:0]   owner_data_c;
    logic                owner_valid_c;
    logic                accept_c;

    preio_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant_c (pick_onehot_c),
        .idx_c   (pick_idx_c),
        .any_c   (pick_any_c)
    );

    // Per-requester slice selection for the picked length and the owner's beat.
    always_comb begin
        pick_len_c    = '0;
        owner_data_c  = '0;
        owner_valid_c = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot_c[i]) begin
                pick_len_c = req_len[i*LEN_W +: LEN_W];
            end
            if (owner == OWN_W'(i)) begin
                owner_data_c  = beat_data[i*DATA_W +: DATA_W];
                owner_valid_c = beat_valid[i];
            end
        end
    end

    assign accept_c = (state == XFER) && soc_rdy_q && owner_valid_c;

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        len_n    = len_q;
        cnt_n    = cnt;
        wd_n     = wd;
        gap_n    = gap_cnt;
        ctrl_n   = '0;
        data_n   = lane_data;
        done_c   = 1'b0;
        grant_n  = '0;
        ready_n  = '0;
        busy_n   = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any_c) begin
                    owner_n = pick_idx_c;
                    len_n   = pick_len_c;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                cnt_n   = len_q;
                wd_n    = '0;
                state_n = XFER;
            end
            XFER: begin
                if (accept_c) begin
                    data_n       = owner_data_c;
                    ctrl_n.valid = 1'b1;
                    ctrl_n.sof   = (cnt == len_q);
                    ctrl_n.eof   = (cnt == '0);
                    wd_n         = '0;
                    if (cnt == '0) begin
                        done_c = 1'b1;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    ctrl_n.err = 1'b1;
                    done_c     = 1'b1;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end
            GAP: begin
                if (32'(gap_cnt) + 32'd1 >= GAP_CYCLES) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Burst ended (normally or by abort): advance priority past the owner.
        if (done_c) begin
            rr_ptr_n = (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            gap_n    = '0;
            state_n  = (GAP_CYCLES == 0) ? IDLE : GAP;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            grant_n[i] = (state_n == GRANT) && (owner_n == OWN_W'(i));
            ready_n[i] = (state_n == XFER) && (owner_n == OWN_W'(i)) && soc_ready_pad;
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            len_q      <= '0;
            cnt        <= '0;
            wd         <= '0;
            gap_cnt    <= '0;
            soc_rdy_q  <= 1'b0;
            ctrl       <= '0;
            lane_data  <= '0;
            req_grant  <= '0;
            beat_ready <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            rr_ptr     <= rr_ptr_n;
            len_q      <= len_n;
            cnt        <= cnt_n;
            wd         <= wd_n;
            gap_cnt    <= gap_n;
            soc_rdy_q  <= soc_ready_pad;
            ctrl       <= ctrl_n;
            lane_data  <= data_n;
            req_grant  <= grant_n;
            beat_ready <= ready_n;
            busy       <= busy_n;
        end
    end

    assign lane_valid = ctrl.valid;
    assign lane_sof   = ctrl.sof;
    assign lane_eof   = ctrl.eof;
    assign lane_err   = ctrl.err;
    assign cur_owner  = owner;

endmodule

// File: tb/tb_preio_f2a_lane_arbiter.sv
// Directed bench for preio_f2a_lane_arbiter: default instance plus a GAP_CYCLES=0 instance.
module tb_preio_f2a_lane_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_len;
    logic [31:0] beat_data;
    logic [3:0]  beat_valid;
    logic        soc_ready_pad;

    logic [3:0]  req_grant, beat_ready;
    logic [7:0]  lane_data;
    logic        lane_valid, lane_sof, lane_eof, lane_err, busy;
    logic [1:0]  cur_owner;

    logic [3:0]  g0_req_grant, g0_beat_ready;
    logic [7:0]  g0_lane_data;
    logic        g0_lane_valid, g0_lane_sof, g0_lane_eof, g0_lane_err, g0_busy;
    logic [1:0]  g0_cur_owner;

    int   src_idx [4];
    int   src_cnt [4];
    logic sel_g0;
    int   errors;
    int   checks;

    preio_f2a_lane_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .LEN_W(4), .GAP_CYCLES(1), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len),
        .req_grant(req_grant), .beat_data(beat_data), .beat_valid(beat_valid),
        .beat_ready(beat_ready), .soc_ready_pad(soc_ready_pad), .lane_data(lane_data),
        .lane_valid(lane_valid), .lane_sof(lane_sof), .lane_eof(lane_eof),
        .lane_err(lane_err), .busy(busy), .cur_owner(cur_owner)
    );

    preio_f2a_lane_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .LEN_W(4), .GAP_CYCLES(0), .TIMEOUT(16)
    ) dut_g0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len),
        .req_grant(g0_req_grant), .beat_data(beat_data), .beat_valid(beat_valid),
        .beat_ready(g0_beat_ready), .soc_ready_pad(soc_ready_pad), .lane_data(g0_lane_data),
        .lane_valid(g0_lane_valid), .lane_sof(g0_lane_sof), .lane_eof(g0_lane_eof),
        .lane_err(g0_lane_err), .busy(g0_busy), .cur_owner(g0_cur_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester i offers beats 0xA0+16*i, +1, ... while src_idx < src_cnt.
    task automatic drive_src();
        for (int i = 0; i < 4; i++) begin
            beat_valid[i]       = (src_idx[i] < src_cnt[i]);
            beat_data[i*8 +: 8] = 8'(32'hA0 + 32'(16 * i) + 32'(src_idx[i]));
        end
    endtask

    // One clock: note handshakes before the edge, then re-drive sources 1ns after it.
    task automatic step();
        logic [3:0] acc;
        acc = beat_valid & (sel_g0 ? g0_beat_ready : beat_ready);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] === 1'b1) src_idx[i]++;
        end
        drive_src();
    endtask

    task automatic do_reset();
        req_valid     = '0;
        req_len       = '0;
        soc_ready_pad = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_idx[i] = 0;
            src_cnt[i] = 0;
        end
        drive_src();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [22:0] got;
        reset = 1'b1;
        step();
        step();
        got = {req_grant, beat_ready, lane_data, lane_valid, lane_sof, lane_eof, lane_err, busy, cur_owner};
        checks++;
        if (got !== 23'd0) begin
            errors++;
            $display("FAIL reset_held outputs got %h want 0", got);
        end
        got = {g0_req_grant, g0_beat_ready, g0_lane_data, g0_lane_valid, g0_lane_sof,
               g0_lane_eof, g0_lane_err, g0_busy, g0_cur_owner};
        checks++;
        if (got !== 23'd0) begin
            errors++;
            $display("FAIL reset_held_g0 outputs got %h want 0", got);
        end
        reset = 1'b0;
        step();
        got = {req_grant, beat_ready, lane_data, lane_valid, lane_sof, lane_eof, lane_err, busy, cur_owner};
        checks++;
        if (got !== 23'd0) begin
            errors++;
            $display("FAIL reset_released outputs got %h want 0", got);
        end
    endtask

    task automatic test_single_burst();
        logic [8:0] got, exp;
        do_reset();
        req_len    = 16'h0003;
        req_valid  = 4'b0001;
        src_cnt[0] = 4;
        drive_src();
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) req_valid = 4'b0000;
            exp = {(c == 1) ? 4'b0001 : 4'b0000, (c >= 3 && c <= 6), (c == 3), (c == 6), 1'b0, (c <= 6)};
            got = {req_grant, lane_valid, lane_sof, lane_eof, lane_err, busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single ctrl c=%0d got %b want %b", c, got, exp);
            end
            if (c >= 3 && c <= 6) begin
                checks++;
                if (lane_data !== 8'(32'hA0 + 32'(c - 3))) begin
                    errors++;
                    $display("FAIL single data c=%0d got %h want %h", c, lane_data, 8'(32'hA0 + 32'(c - 3)));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got, exp;
        logic [3:0] eg;
        int         o;
        logic [7:0] ed;
        do_reset();
        req_len   = 16'h0000;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) src_cnt[i] = 4;
        drive_src();
        for (int c = 1; c <= 20; c++) begin
            step();
            eg = 4'b0000;
            if (c % 4 == 1) begin
                o  = ((c - 1) / 4) % 4;
                eg = 4'(1 << o);
            end
            exp = {eg, (c % 4 == 3), (c % 4 == 3), (c % 4 == 3), 1'b0, (c % 4 != 0)};
            got = {req_grant, lane_valid, lane_sof, lane_eof, lane_err, busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b ctrl c=%0d got %b want %b", c, got, exp);
            end
            if (c % 4 == 1) begin
                checks++;
                if (cur_owner !== 2'(o)) begin
                    errors++;
                    $display("FAIL b2b owner c=%0d got %0d want %0d", c, cur_owner, o);
                end
            end
            if (c % 4 == 3) begin
                o  = ((c - 3) / 4) % 4;
                ed = 8'(32'hA0 + 32'(16 * o) + ((c == 19) ? 32'd1 : 32'd0));
                checks++;
                if (lane_data !== ed) begin
                    errors++;
                    $display("FAIL b2b data c=%0d got %h want %h", c, lane_data, ed);
                end
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        logic [12:0] got, exp;
        logic [3:0]  er;
        do_reset();
        req_len    = 16'h0002;
        req_valid  = 4'b0001;
        src_cnt[0] = 3;
        drive_src();
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) req_valid = 4'b0000;
            soc_ready_pad = !(c == 2 || c == 3);
            er  = (c == 2 || c == 5 || c == 6) ? 4'b0001 : 4'b0000;
            exp = {er, (c == 1) ? 4'b0001 : 4'b0000, (c == 3 || c == 6 || c == 7), (c == 3), (c == 7),
                   1'b0, (c <= 7)};
            got = {beat_ready, req_grant, lane_valid, lane_sof, lane_eof, lane_err, busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bp ctrl c=%0d got %b want %b", c, got, exp);
            end
            if (c == 3 || c == 6 || c == 7) begin
                checks++;
                if (lane_data !== ((c == 3) ? 8'hA0 : (c == 6) ? 8'hA1 : 8'hA2)) begin
                    errors++;
                    $display("FAIL bp data c=%0d got %h", c, lane_data);
                end
            end
        end
        checks++;
        if (src_idx[0] !== 3) begin
            errors++;
            $display("FAIL bp beats_taken got %0d want 3", src_idx[0]);
        end
    endtask

    task automatic test_watchdog();
        logic [8:0] got, exp;
        logic       ev;
        do_reset();
        req_len    = 16'h0005;
        req_valid  = 4'b0011;
        src_cnt[0] = 2;
        src_cnt[1] = 1;
        drive_src();
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 22) req_valid = 4'b0000;
            ev  = (c == 3 || c == 4 || c == 24);
            exp = {(c == 1) ? 4'b0001 : (c == 22) ? 4'b0010 : 4'b0000, ev, (c == 3 || c == 24),
                   (c == 24), (c == 20), (c != 21)};
            got = {req_grant, lane_valid, lane_sof, lane_eof, lane_err, busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wdog ctrl c=%0d got %b want %b", c, got, exp);
            end
            if (c == 22) begin
                checks++;
                if (cur_owner !== 2'd1) begin
                    errors++;
                    $display("FAIL wdog next_owner got %0d want 1", cur_owner);
                end
            end
            if (ev) begin
                checks++;
                if (lane_data !== ((c == 3) ? 8'hA0 : (c == 4) ? 8'hA1 : 8'hB0)) begin
                    errors++;
                    $display("FAIL wdog data c=%0d got %h", c, lane_data);
                end
            end
        end
    endtask

    task automatic test_reset_midburst();
        logic [22:0] got;
        do_reset();
        req_len    = 16'h0300;
        req_valid  = 4'b0010;
        src_cnt[1] = 1;
        src_cnt[2] = 4;
        drive_src();
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) req_valid = 4'b0000;
            if (c == 4) req_valid = 4'b0100;
            if (c == 5) begin
                req_valid = 4'b0000;
                checks++;
                if (req_grant !== 4'b0100) begin
                    errors++;
                    $display("FAIL midrst pre_grant got %b want 0100", req_grant);
                end
            end
        end
        checks++;
        if ({lane_valid, lane_sof, lane_data} !== {1'b1, 1'b1, 8'hC0}) begin
            errors++;
            $display("FAIL midrst beat0 got %b %b %h want 1 1 c0", lane_valid, lane_sof, lane_data);
        end
        #3;
        reset = 1'b1;
        #1;
        got = {req_grant, beat_ready, lane_data, lane_valid, lane_sof, lane_eof, lane_err, busy, cur_owner};
        checks++;
        if (got !== 23'd0) begin
            errors++;
            $display("FAIL midrst async_zero got %h want 0", got);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_idx[i] = 0;
            src_cnt[i] = 0;
        end
        req_len   = 16'h0000;
        req_valid = 4'b1001;
        drive_src();
        step();
        checks++;
        if ({req_grant, cur_owner, lane_valid, lane_eof} !== {4'b0001, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst regrant got %b/%0d/%b%b want 0001/0/00", req_grant, cur_owner,
                     lane_valid, lane_eof);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_gap0();
        logic [8:0] got, exp;
        sel_g0 = 1'b1;
        do_reset();
        req_len    = 16'h0000;
        req_valid  = 4'b1010;
        src_cnt[1] = 4;
        src_cnt[3] = 4;
        drive_src();
        for (int c = 1; c <= 9; c++) begin
            step();
            exp = {(c == 1 || c == 7) ? 4'b0010 : (c == 4) ? 4'b1000 : 4'b0000, (c % 3 == 0),
                   (c % 3 == 0), (c % 3 == 0), 1'b0, (c % 3 != 0)};
            got = {g0_req_grant, g0_lane_valid, g0_lane_sof, g0_lane_eof, g0_lane_err, g0_busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL gap0 ctrl c=%0d got %b want %b", c, got, exp);
            end
            if (c % 3 == 0) begin
                checks++;
                if (g0_lane_data !== ((c == 3) ? 8'hB0 : (c == 6) ? 8'hD0 : 8'hB1)) begin
                    errors++;
                    $display("FAIL gap0 data c=%0d got %h", c, g0_lane_data);
                end
            end
        end
        req_valid = 4'b0000;
        sel_g0    = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        sel_g0        = 1'b0;
        reset         = 1'b1;
        soc_ready_pad = 1'b1;
        req_valid     = '0;
        req_len       = '0;
        for (int i = 0; i < 4; i++) begin
            src_idx[i] = 0;
            src_cnt[i] = 0;
        end
        drive_src();
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_backpressure();
        test_watchdog();
        test_reset_midburst();
        test_gap0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
